// File: rtl/intc_pkg.sv
// Purpose : shared types, widths and the vector-address helper for the interrupt controller.
// Latency : n/a (definitions only).
// Backpr. : n/a.
// Contents: intc_state_e (IDLE/REQUEST/SERVICE), VEC_W, SEL_W, vec_addr().
package intc_pkg;

  localparam int VEC_W = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } intc_state_e;

  // Handler address of slot 'sel'; wraps modulo 2^VEC_W.
  function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0] base,
                                                input logic [VEC_W-1:0] stride,
                                                input logic [SEL_W-1:0] sel);
    logic [VEC_W-1:0] sel_ext;
    sel_ext = VEC_W'(sel);
    return base + (sel_ext * stride);
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Purpose : fixed-priority encoder; reports whether any request is set and the lowest set index.
// Latency : combinational.
// Backpr. : none.
// Ports   : req_i (N requests), vld_o (any set), idx_o (lowest set index, 0 when none).
module irq_priority_encoder
  import intc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  output logic             vld_o,
  output logic [SEL_W-1:0] idx_o
);

  // Walk from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = SEL_W'(i);
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/interrupt_controller.sv
// Purpose : latches IRQ sources, picks the highest-priority enabled one and requests the CPU;
//           pulses mask_int on acknowledge and unmask_int on return-from-interrupt.
// Latency : irq edge -> int_req 2 cycles; cpu_ack/reti -> mask_int/unmask_int 1 cycle.
// Backpr. : request is held until cpu_ack or withdrawn when flag_mask rises; no nesting.
// Config  : define INTC_LEVEL_EN for level-sensitive sources (pending = registered irq,
//           acknowledge does not clear); default is rising-edge latched sources.
// Ports   : clk, rst (sync, active-high); irq, irq_en, flag_mask, cpu_ack, reti in;
//           int_req, int_vector, mask_int, unmask_int, in_service, pending out.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int               NUM_IRQ       = 4,
  parameter logic [VEC_W-1:0] VECTOR_BASE   = 16'h0010,
  parameter int               VECTOR_STRIDE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               flag_mask,
  input  logic               cpu_ack,
  input  logic               reti,
  output logic               int_req,
  output logic [VEC_W-1:0]   int_vector,
  output logic               mask_int,
  output logic               unmask_int,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  intc_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               mask_q, unmask_q;
  logic               ack_take, ret_take;
  logic               cand_vld;
  logic [SEL_W-1:0]   cand_idx;

  irq_priority_encoder #(.N(NUM_IRQ)) u_enc (
    .req_i (pending_q & irq_en),
    .vld_o (cand_vld),
    .idx_o (cand_idx)
  );

  // Next-state: sel is only reloaded on the IDLE->REQUEST transition, so a
  // later higher-priority arrival cannot change a request already in flight.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ack_take = 1'b0;
    ret_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_vld && !flag_mask) begin
          state_d = REQUEST;
          sel_d   = cand_idx;
        end
      end
      REQUEST: begin
        // Acknowledge takes precedence over a simultaneous mask.
        if (cpu_ack) begin
          state_d  = SERVICE;
          ack_take = 1'b1;
        end else if (flag_mask) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (reti) begin
          state_d  = IDLE;
          ret_take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef INTC_LEVEL_EN
  // Level-sensitive: pending mirrors the lines one cycle late.
  always_comb begin
    pending_d = irq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] clr_vec;

  // A new edge on the same cycle as the acknowledge clear keeps the bit set.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = ack_take && (sel_q == SEL_W'(i));
    end
    pending_d = (pending_q & ~clr_vec) | (irq & ~irq_prev_q);
  end

  // Edge register reloads from irq in reset so lines already high do not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      irq_prev_q <= irq;
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= irq;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      mask_q   <= 1'b0;
      unmask_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      // Pulses derive from entering and leaving SERVICE, which cannot happen
      // on the same edge, so mask and unmask never overlap.
      mask_q   <= ack_take;
      unmask_q <= ret_take;
    end
  end

  assign int_req    = (state_q == REQUEST);
  assign in_service = (state_q == SERVICE);
  assign mask_int   = mask_q;
  assign unmask_int = unmask_q;
  assign pending    = pending_q;
  assign int_vector = vec_addr(VECTOR_BASE, VEC_W'(VECTOR_STRIDE), sel_q);

endmodule

// File: tb/tb_interrupt_controller.sv
// Purpose : directed self-checking bench for interrupt_controller (NUM_IRQ = 4).
// Latency : checks are made 1 time unit after each rising edge.
// Backpr. : n/a.
module tb_interrupt_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  irq;
  logic [3:0]  irq_en;
  logic        flag_mask;
  logic        cpu_ack;
  logic        reti;
  logic        int_req;
  logic [15:0] int_vector;
  logic        mask_int;
  logic        unmask_int;
  logic        in_service;
  logic [3:0]  pending;

  int total;
  int bad;

  interrupt_controller #(
    .NUM_IRQ       (4),
    .VECTOR_BASE   (16'h0010),
    .VECTOR_STRIDE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .irq_en     (irq_en),
    .flag_mask  (flag_mask),
    .cpu_ack    (cpu_ack),
    .reti       (reti),
    .int_req    (int_req),
    .int_vector (int_vector),
    .mask_int   (mask_int),
    .unmask_int (unmask_int),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    irq       = 4'b0000;
    irq_en    = 4'b1111;
    flag_mask = 1'b0;
    cpu_ack   = 1'b0;
    reti      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_req", 32'(int_req), 32'h0);
    chk("rst_mask", 32'(mask_int), 32'h0);
    chk("rst_unmask", 32'(unmask_int), 32'h0);
    chk("rst_insvc", 32'(in_service), 32'h0);
    chk("rst_vec", 32'(int_vector), 32'h0010);

    // Edge fires: irq[2] rises, request two cycles later
    irq = 4'b0100;
    tick();
    chk("e_pend", 32'(pending), 32'h4);
    chk("e_req_early", 32'(int_req), 32'h0);
    tick();
    chk("e_req", 32'(int_req), 32'h1);
    chk("e_vec", 32'(int_vector), 32'h0014);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("e_mask", 32'(mask_int), 32'h1);
    chk("e_pend_clr", 32'(pending), 32'h0);
    chk("e_req_drop", 32'(int_req), 32'h0);
    chk("e_insvc", 32'(in_service), 32'h1);
    tick();
    chk("e_mask_pulse", 32'(mask_int), 32'h0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("e_unmask", 32'(unmask_int), 32'h1);
    chk("e_insvc_off", 32'(in_service), 32'h0);
    tick();
    chk("e_unmask_pulse", 32'(unmask_int), 32'h0);
    chk("e_no_rereq", 32'(int_req), 32'h0);
    irq = 4'b0000;
    tick();

    // Priority: irq[3] and irq[1] together
    irq = 4'b1010;
    tick();
    chk("p_pend", 32'(pending), 32'hA);
    tick();
    chk("p_req1", 32'(int_req), 32'h1);
    chk("p_vec1", 32'(int_vector), 32'h0012);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("p_pend_after", 32'(pending), 32'h8);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("p_unmask", 32'(unmask_int), 32'h1);
    chk("p_gap", 32'(int_req), 32'h0);
    tick();
    chk("p_req2", 32'(int_req), 32'h1);
    chk("p_vec2", 32'(int_vector), 32'h0016);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    irq = 4'b0000;
    tick();

    // Masking: irq[0] rises while masked
    flag_mask = 1'b1;
    irq = 4'b0001;
    tick();
    chk("m_pend", 32'(pending), 32'h1);
    tick();
    chk("m_req_a", 32'(int_req), 32'h0);
    tick();
    chk("m_req_b", 32'(int_req), 32'h0);
    flag_mask = 1'b0;
    tick();
    chk("m_req", 32'(int_req), 32'h1);
    chk("m_vec", 32'(int_vector), 32'h0010);

    // Withdraw: mask rises in REQUEST without ack
    flag_mask = 1'b1;
    tick();
    chk("w_req_drop", 32'(int_req), 32'h0);
    chk("w_pend_kept", 32'(pending), 32'h1);
    chk("w_no_mask", 32'(mask_int), 32'h0);
    flag_mask = 1'b0;
    tick();
    chk("w_rereq", 32'(int_req), 32'h1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("w_insvc", 32'(in_service), 32'h1);
    irq = 4'b0000;
    tick();

    // Service/return: new edge during SERVICE waits for reti
    irq = 4'b0001;
    tick();
    chk("s_pend", 32'(pending), 32'h1);
    chk("s_no_req_a", 32'(int_req), 32'h0);
    tick();
    chk("s_no_req_b", 32'(int_req), 32'h0);
    chk("s_insvc", 32'(in_service), 32'h1);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("s_unmask", 32'(unmask_int), 32'h1);
    chk("s_no_overlap", 32'(mask_int), 32'h0);
    tick();
    chk("s_req", 32'(int_req), 32'h1);
    chk("s_vec", 32'(int_vector), 32'h0010);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    // Stray reti and cpu_ack in IDLE are ignored
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("s_stray_reti", 32'(unmask_int), 32'h0);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("s_stray_ack", 32'(mask_int), 32'h0);
    irq = 4'b0000;
    tick();

    // Reset mid-SERVICE with irq[1] held high
    irq = 4'b0010;
    tick();
    tick();
    chk("r_req", 32'(int_req), 32'h1);
    chk("r_vec_pre", 32'(int_vector), 32'h0012);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("r_insvc_pre", 32'(in_service), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_insvc", 32'(in_service), 32'h0);
    chk("r_req_off", 32'(int_req), 32'h0);
    chk("r_unmask", 32'(unmask_int), 32'h0);
    chk("r_mask", 32'(mask_int), 32'h0);
    chk("r_pend", 32'(pending), 32'h0);
    chk("r_vec", 32'(int_vector), 32'h0010);
    tick();
    tick();
    tick();
`ifdef INTC_LEVEL_EN
    chk("r_level_req", 32'(int_req), 32'h1);
    chk("r_level_vec", 32'(int_vector), 32'h0012);
`else
    chk("r_edge_noreq", 32'(int_req), 32'h0);
    chk("r_edge_nopend", 32'(pending), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
